order_scheduler: RTL
====================

# order_scheduler

Game-progress controller that produces the per-frame game status consumed by the graphics block: `game_state`, `time_left`, `point_total`, `orders` and `order_times`. It runs the round state machine, divides the pixel clock down to 1 s ticks, spawns and ages customer orders in a fixed-depth age-ordered queue, and scores serves and expiries. All outputs are registered and remain stable between ticks, so the renderer samples them without further synchronisation.

## Interface
- `CLK_HZ`, 65_000_000: clock cycles per second.
- `GAME_SECONDS`, 180: round length; ≤255.
- `ORDER_SECONDS`, 30: lifetime of a new order; 1..31.
- `ORDER_GAP_SECONDS`, 20: ticks between spawn attempts; ≥1.
- `POINTS_PER_ORDER`, 20: base credit per serve.
- `PENALTY`, 10: debit per expired order.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a round.
- `serve`  in  1  one-cycle pulse; full bowl delivered.
- `game_state`  out  3  0 WELCOME, 1 PLAYING, 2 GAME_OVER.
- `time_left`  out  8  seconds remaining.
- `point_total`  out  10  score.
- `orders`  out  4  active order count, 0..4.
- `order_times`  out  [3:0][4:0]  seconds left per slot; slot 0 oldest; unused slots read 0.
- `tick`  out  1  one-cycle pulse per elapsed second while PLAYING.

## Operation
- Reset: WELCOME, `time_left`=GAME_SECONDS, `point_total`=0, `orders`=0, all `order_times`=0, `tick`=0, prescaler and gap counter 0.
- WELCOME or GAME_OVER + `start` → PLAYING: `time_left`=GAME_SECONDS, `point_total`=0, prescaler=0, gap=0, queue = one order (slot 0 = ORDER_SECONDS, `orders`=1). `start` is ignored while PLAYING.
- Prescaler counts 0..CLK_HZ-1 only in PLAYING; `tick` asserts on the cycle it wraps.
- On tick: `time_left` decrements; every active slot decrements; a slot reaching 0 expires (point_total −PENALTY, saturating at 0, per expired order); survivors compact toward slot 0 in age order. Gap counter increments; on reaching ORDER_GAP_SECONDS it clears and one order (ORDER_SECONDS, not decremented this tick) appends after compaction if `orders`<4, else the spawn is dropped.
- `serve` in PLAYING with `orders`>0: slot 0 removed, point_total += POINTS_PER_ORDER + its pre-tick `order_times[0]`, saturating at 1023. With `orders`=0, or outside PLAYING, `serve` is ignored.
- `serve` and tick in the same cycle: serve consumes slot 0 at its pre-tick value (and slot 0 is never also charged an expiry); remaining slots follow the tick rules; spawn appends last.
- A tick that takes `time_left` 1→0 enters GAME_OVER on the same edge: queue cleared, `order_times` zeroed, score held, prescaler stops.

## Timing
- All outputs update on the clock edge that samples the event; visible the following cycle. No combinational paths from inputs to outputs.
- First tick occurs CLK_HZ cycles after the `start` edge.
- Asserting reset mid-round returns every output to its reset value immediately (asynchronously); first edge after release behaves as from WELCOME.

## Structure
- `game_pkg`: game-state enum (WELCOME/PLAYING/GAME_OVER), MAX_ORDERS=4, order-time width 5, score width 10, score saturation constant; shared with graphics and game logic.
- Sub-module `second_prescaler` (CLK_HZ parameter; enable, clear in; tick out). The queue update (decrement, expire mask, compaction, append) is one combinational next-state function plus registers in the top.

## Test plan
Bench parameters: CLK_HZ=4, GAME_SECONDS=5, ORDER_SECONDS=3, ORDER_GAP_SECONDS=2, POINTS_PER_ORDER=20, PENALTY=10.
- Reset, then `start` → PLAYING, time_left 5, orders 1, order_times[0]=3; after 4 cycles tick, time_left 4, order_times[0]=2.
- After first tick, `serve` → point_total 22, orders 0; second `serve` with orders 0 → no change.
- No serves: tick 2 spawns (orders 2, times 1,3); tick 3 expires slot 0 → orders 1, order_times[0]=2, score stays 0; repeat after a 22-point serve → score 12.
- Run to tick 5 → GAME_OVER, time_left 0, orders 0, order_times all 0; `serve` ignored; `start` → PLAYING, score 0, time_left 5.
- ORDER_GAP_SECONDS=1, ORDER_SECONDS=31, GAME_SECONDS=255: orders reaches 4 at tick 3, stays 4 thereafter; `serve` together with tick with times 28,29,30,31 → point_total 48, orders 3, times 28,29,30 (spawn lands next gap tick).
- Assert reset mid-round at time_left 3 → all outputs reset values before the next edge; `start` restarts cleanly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: round states, queue geometry, score width and the
// saturating score helper used by the scheduler and the graphics side.
package game_pkg;

  typedef enum logic [2:0] {
    WELCOME   = 3'd0,
    PLAYING   = 3'd1,
    GAME_OVER = 3'd2
  } game_state_t;

  localparam int MAX_ORDERS   = 4;
  localparam int ORDER_TIME_W = 5;
  localparam int SCORE_W      = 10;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Clamp a signed intermediate score into 0..SCORE_MAX.
  function automatic logic [SCORE_W-1:0] sat_score(input int v);
    if (v < 0) return '0;
    else if (v > int'(SCORE_MAX)) return SCORE_MAX;
    else return v[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/second_prescaler.sv
// Divides the pixel clock down to a one-cycle pulse per elapsed second.
// The pulse is combinational on the wrap cycle; the caller registers it.
module second_prescaler #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] count;

  assign tick = enable && !clear && (count == CNT_W'(CLK_HZ - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/order_scheduler.sv
// Round controller: game state machine, 1 s timebase, age-ordered order queue
// with ageing/expiry/compaction/spawn, and serve/expiry scoring.
module order_scheduler
  import game_pkg::*;
#(
  parameter int CLK_HZ            = 65_000_000,
  parameter int GAME_SECONDS      = 180,
  parameter int ORDER_SECONDS     = 30,
  parameter int ORDER_GAP_SECONDS = 20,
  parameter int POINTS_PER_ORDER  = 20,
  parameter int PENALTY           = 10
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     serve,
  output logic [2:0]                               game_state,
  output logic [7:0]                               time_left,
  output logic [SCORE_W-1:0]                       point_total,
  output logic [3:0]                               orders,
  output logic [MAX_ORDERS-1:0][ORDER_TIME_W-1:0] order_times,
  output logic                                     tick
);

  localparam int GAP_W = $clog2(ORDER_GAP_SECONDS + 1);
  localparam logic [ORDER_TIME_W-1:0] NEW_ORDER = ORDER_TIME_W'(ORDER_SECONDS);

  game_state_t                              state_q, state_d;
  logic [7:0]                               time_q;
  logic [SCORE_W-1:0]                       score_q, score_d;
  logic [2:0]                               cnt_q, cnt_d;
  logic [MAX_ORDERS-1:0][ORDER_TIME_W-1:0] times_q, times_d;
  logic [GAP_W-1:0]                         gap_q, gap_inc;
  logic                                     tick_q;

  logic                    playing, start_game, sec_tick, serve_ok;
  logic                    spawn_due, round_end;
  logic [ORDER_TIME_W-1:0] slot;
  logic [2:0]              n_expired;

  // start and serve are single-cycle pulses sampled on the rising edge; there is
  // no ready: a pulse is either acted on in that cycle or dropped for good.
  assign playing    = (state_q == PLAYING);
  assign start_game = start && !playing;
  assign serve_ok   = serve && playing && (cnt_q != 3'd0);
  assign gap_inc    = gap_q + 1'b1;
  assign spawn_due  = sec_tick && (gap_inc == GAP_W'(ORDER_GAP_SECONDS));
  assign round_end  = sec_tick && (time_q == 8'd1);

  second_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (playing),
    .clear  (start_game),
    .tick   (sec_tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WELCOME, GAME_OVER: if (start) state_d = PLAYING;
      PLAYING:            if (round_end) state_d = GAME_OVER;
      default:            state_d = WELCOME;
    endcase
  end

  // Queue next state: a served head is skipped, the rest age and either expire
  // or pack toward slot 0; a due spawn appends last if the pre-tick queue had room.
  always_comb begin
    times_d   = '0;
    cnt_d     = '0;
    n_expired = '0;
    slot      = '0;
    for (int i = 0; i < MAX_ORDERS; i++) begin
      if ((3'(i) < cnt_q) && !(serve_ok && (i == 0))) begin
        slot = times_q[i];
        if (sec_tick) slot = slot - 1'b1;
        if (slot == '0) begin
          n_expired = n_expired + 1'b1;
        end else begin
          times_d[cnt_d[1:0]] = slot;
          cnt_d = cnt_d + 1'b1;
        end
      end
    end
    if (spawn_due && (cnt_q < 3'(MAX_ORDERS))) begin
      times_d[cnt_d[1:0]] = NEW_ORDER;
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_comb begin
    score_d = sat_score(int'(score_q)
                        + (serve_ok ? POINTS_PER_ORDER + int'(times_q[0]) : 0)
                        - PENALTY * int'(n_expired));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WELCOME;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_q  <= 8'(GAME_SECONDS);
      score_q <= '0;
      cnt_q   <= '0;
      times_q <= '0;
      gap_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= sec_tick;
      if (start_game) begin
        time_q  <= 8'(GAME_SECONDS);
        score_q <= '0;
        cnt_q   <= 3'd1;
        times_q <= {{((MAX_ORDERS - 1) * ORDER_TIME_W){1'b0}}, NEW_ORDER};
        gap_q   <= '0;
      end else if (playing) begin
        score_q <= score_d;
        if (round_end) begin
          time_q  <= '0;
          cnt_q   <= '0;
          times_q <= '0;
          gap_q   <= '0;
        end else begin
          cnt_q   <= cnt_d;
          times_q <= times_d;
          if (sec_tick) begin
            time_q <= time_q - 1'b1;
            gap_q  <= spawn_due ? '0 : gap_inc;
          end
        end
      end
    end
  end

  assign game_state  = state_q;
  assign time_left   = time_q;
  assign point_total = score_q;
  assign orders      = {1'b0, cnt_q};
  assign order_times = times_q;
  assign tick        = tick_q;

endmodule
